key_sw_input: RTL and testbench

KEY_SW_INPUT -- requirements
Module: key_sw_input

---
 rtl/key_sw_input.sv | 170 +++++++++++++++++
 tb/tb_key_sw_input.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sw_input.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// key_sw_input
//
// Memory-mapped input block for four active-low board pushbuttons and ten
// slide switches. Every raw input bit is synchronised into the clk domain,
// debounced, and exposed on the load/store bus as three read registers:
//
//   ADDR_KEY   : KDATA = pressed keys, one bit per key (1 = pressed)
//   ADDR_SW    : SDATA = debounced switch levels
//   ADDR_KCTRL : KCTRL = [3:0] sticky press-edge flags, [4] sticky overrun
//
// KCTRL bits [4:0] are write-1-to-clear; a press edge arriving in the same
// cycle as a clear of the same bit keeps that bit set. Reads never change
// state.
//
// Ports
//   clk      in   system clock, all state changes on the rising edge
//   reset    in   asynchronous active-low reset (0 = reset, 1 = run)
//   key_in   in   [3:0]  raw pushbuttons, active-low, asynchronous to clk
//   sw_in    in   [9:0]  raw switches, asynchronous to clk
//   addr     in   [DBITS-1:0] bus address
//   wr_en    in   bus store strobe
//   wr_data  in   [DBITS-1:0] bus store data
//   rd_data  out  [DBITS-1:0] bus load data, combinational from addr
//   rd_hit   out  high when addr selects one of the three registers
// -----------------------------------------------------------------------------
module key_sw_input #(
   parameter int unsigned      DBITS           = 32,
   parameter int unsigned      DEBOUNCE_CYCLES = 250000,
   parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF0000010,
   parameter logic [DBITS-1:0] ADDR_SW         = 32'hF0000014,
   parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       key_in,
   input  logic [9:0]       sw_in,
   input  logic [DBITS-1:0] addr,
   input  logic             wr_en,
   input  logic [DBITS-1:0] wr_data,
   output logic [DBITS-1:0] rd_data,
   output logic             rd_hit
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   // Keys and switches share one debounce datapath: bits [3:0] are the keys,
   // bits [13:4] the switches.
   localparam int unsigned NKEY = 4;
   localparam int unsigned NSW  = 10;
   localparam int unsigned NB   = NKEY + NSW;

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   // Last count value before acceptance: on the edge the counter would reach
   // DEBOUNCE_CYCLES the new level is taken instead.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // Released keys are high, switches reset low.
   localparam logic [NB-1:0] RST_VAL = {{NSW{1'b0}}, {NKEY{1'b1}}};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [NB-1:0] raw;
   logic [NB-1:0] sync1_q;
   logic [NB-1:0] sync2_q;
   logic [NB-1:0] stable_q, stable_d;
   logic [CW-1:0] cnt_q [NB];
   logic [CW-1:0] cnt_d [NB];

   logic [4:0]      kctrl_q, kctrl_d;
   logic [NKEY-1:0] press_evt;
   logic [4:0]      kctrl_clr;
   logic            kctrl_wr;

   // Only the low five store bits mean anything to this block.
   logic unused_wr_data;
   assign unused_wr_data = ^wr_data[DBITS-1:5];

   assign raw = {sw_in, key_in};

   // ---------------------------------------------------------------------------
   // Debounce next-state
   //
   // A bit's counter runs only while the synchronised input disagrees with
   // the accepted level; any agreement clears it, so a glitch shorter than
   // DEBOUNCE_CYCLES never reaches the accepted level.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      stable_d = stable_q;
      for (int b = 0; b < NB; b++) begin
         cnt_d[b] = '0;
         if (sync2_q[b] != stable_q[b]) begin
            if (cnt_q[b] == CNT_LAST) begin
               stable_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // KCTRL next-state
   //
   // A press edge is a key whose accepted level falls on this edge, taken
   // from stable_d so the flag rises on the same edge as KDATA. Overrun uses
   // the flag value before this edge: a press on an already-flagged key.
   // The set term is OR-ed after the clear mask so a simultaneous set wins.
   // ---------------------------------------------------------------------------
   assign press_evt = stable_q[NKEY-1:0] & ~stable_d[NKEY-1:0];
   assign kctrl_wr  = wr_en && (addr == ADDR_KCTRL);
   assign kctrl_clr = kctrl_wr ? wr_data[4:0] : 5'b0;

   always_comb begin
      kctrl_d = (kctrl_q & ~kctrl_clr)
              | {|(press_evt & kctrl_q[NKEY-1:0]), press_evt};
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q  <= RST_VAL;
         sync2_q  <= RST_VAL;
         stable_q <= RST_VAL;
         // NOTE: the counter array is reset element by element; a partial
         // count must not survive reset, so it is not left as bare storage.
         for (int b = 0; b < NB; b++) begin
            cnt_q[b] <= '0;
         end
         kctrl_q <= '0;
      end else begin
         // NOTE: non-blocking assignments let the two synchroniser stages
         // shift in one edge; blocking ones would collapse them into one flop.
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         for (int b = 0; b < NB; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
         kctrl_q <= kctrl_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Bus read mux (combinational, side-effect free)
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_hit  = 1'b0;
      rd_data = '0;
      if (addr == ADDR_KEY) begin
         rd_hit  = 1'b1;
         rd_data = {{(DBITS-NKEY){1'b0}}, ~stable_q[NKEY-1:0]};
      end else if (addr == ADDR_SW) begin
         rd_hit  = 1'b1;
         rd_data = {{(DBITS-NSW){1'b0}}, stable_q[NB-1:NKEY]};
      end else if (addr == ADDR_KCTRL) begin
         rd_hit  = 1'b1;
         rd_data = {{(DBITS-5){1'b0}}, kctrl_q};
      end
   end

endmodule

// File: tb/tb_key_sw_input.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_key_sw_input
//
// Directed and randomised stimulus for key_sw_input with DEBOUNCE_CYCLES = 4.
// The reference model keeps a history of raw input samples: a bit's accepted
// level flips once the D samples that have crossed the two synchroniser
// stages all disagree with it.
// -----------------------------------------------------------------------------
module tb_key_sw_input;

   localparam int unsigned D       = 4;
   localparam logic [31:0] A_KEY   = 32'hF0000010;
   localparam logic [31:0] A_SW    = 32'hF0000014;
   localparam logic [31:0] A_KCTRL = 32'hF0000110;
   localparam logic [31:0] A_NONE  = 32'hF0000000;
   localparam logic [13:0] RST_RAW = {10'b0, 4'hF};

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key_in;
   logic [9:0]  sw_in;
   logic [31:0] addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_hit;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0]  cur_key;
   logic [9:0]  cur_sw;
   logic [31:0] v;

   key_sw_input #(
      .DBITS           (32),
      .DEBOUNCE_CYCLES (D),
      .ADDR_KEY        (A_KEY),
      .ADDR_SW         (A_SW),
      .ADDR_KCTRL      (A_KCTRL)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .key_in  (key_in),
      .sw_in   (sw_in),
      .addr    (addr),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .rd_hit  (rd_hit)
   );

   always #10 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   logic [13:0] hist [$];   // hist[0] = newest raw sample
   logic [13:0] m_stable;   // {sw, key} accepted levels
   logic [4:0]  m_kctrl;

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < int'(D) + 2; i++) hist.push_back(RST_RAW);
      m_stable = RST_RAW;
      m_kctrl  = '0;
   endfunction

   function automatic void model_edge();
      logic [13:0] old;
      logic [3:0]  press;
      logic [4:0]  clr;
      logic        flip;
      logic [13:0] dropped;
      old = m_stable;
      hist.push_front({sw_in, key_in});
      dropped = hist.pop_back();
      for (int b = 0; b < 14; b++) begin
         flip = 1'b1;
         for (int j = 2; j < int'(D) + 2; j++) begin
            if (hist[j][b] == old[b]) flip = 1'b0;
         end
         if (flip) m_stable[b] = ~old[b];
      end
      press   = old[3:0] & ~m_stable[3:0];
      clr     = (wr_en && addr == A_KCTRL) ? wr_data[4:0] : 5'b0;
      m_kctrl = (m_kctrl & ~clr) | {|(press & m_kctrl[3:0]), press};
   endfunction

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic read(input logic [31:0] a, output logic [31:0] val);
      addr = a;
      #1;
      val = rd_data;
   endtask

   // Reads every register plus an unmapped address against the model.
   task automatic check_all();
      logic [31:0] r;
      read(A_KEY, r);
      check("kdata", r, {28'b0, ~m_stable[3:0]});
      check("hit_key", {31'b0, rd_hit}, 32'd1);
      read(A_SW, r);
      check("sdata", r, {22'b0, m_stable[13:4]});
      check("hit_sw", {31'b0, rd_hit}, 32'd1);
      read(A_KCTRL, r);
      check("kctrl", r, {27'b0, m_kctrl});
      check("hit_kctrl", {31'b0, rd_hit}, 32'd1);
      read(A_NONE, r);
      check("data_none", r, 32'd0);
      check("hit_none", {31'b0, rd_hit}, 32'd0);
   endtask

   // One clock: drive at the falling edge, model at the rising edge, check
   // just after it, end on the next falling edge.
   task automatic step(input logic [3:0] k, input logic [9:0] s,
                       input logic we, input logic [31:0] wa,
                       input logic [31:0] wd);
      key_in  = k;
      sw_in   = s;
      wr_en   = we;
      addr    = wa;
      wr_data = wd;
      @(posedge clk);
      model_edge();
      #1;
      wr_en = 1'b0;
      check_all();
      @(negedge clk);
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(cur_key, cur_sw, 1'b0, A_NONE, 32'd0);
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      reset   = 1'b1;
      key_in  = 4'hF;
      sw_in   = '0;
      wr_en   = 1'b0;
      addr    = '0;
      wr_data = '0;
      cur_key = 4'hF;
      cur_sw  = '0;
      model_reset();

      // Reset is visible without any clock edge.
      #2 reset = 1'b0;
      #1 check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Idle after reset: all registers read 0.
      hold(3);

      // Key 0 press: accepted on exactly the 6th edge, edge flag with it.
      cur_key = 4'hE;
      hold(5);
      read(A_KEY, v);   check("k0_before", v, 32'h0);
      read(A_KCTRL, v); check("k0_flag_before", v, 32'h0);
      hold(1);
      read(A_KEY, v);   check("k0_kdata", v, 32'h1);
      read(A_KCTRL, v); check("k0_kctrl", v, 32'h1);
      cur_key = 4'hF;
      hold(8);
      step(cur_key, cur_sw, 1'b1, A_KCTRL, 32'h1F);
      read(A_KCTRL, v); check("k0_cleared", v, 32'h0);

      // Key 1 glitch of 3 cycles is rejected.
      cur_key = 4'hD;
      hold(3);
      cur_key = 4'hF;
      hold(8);
      read(A_KEY, v);   check("glitch_kdata", v, 32'h0);
      read(A_KCTRL, v); check("glitch_kctrl", v, 32'h0);

      // Switch pattern accepted after 6 edges.
      cur_sw = 10'h2A5;
      hold(5);
      read(A_SW, v); check("sw_before", v, 32'h0);
      hold(1);
      read(A_SW, v); check("sw_after", v, 32'h2A5);

      // Key 2 pressed twice without clearing: edge flag plus overrun.
      repeat (2) begin
         cur_key = 4'hB;
         hold(7);
         cur_key = 4'hF;
         hold(7);
      end
      read(A_KCTRL, v); check("k2_overrun", v, 32'h14);
      step(cur_key, cur_sw, 1'b1, A_KCTRL, 32'h14);
      read(A_KCTRL, v); check("w1c_clear", v, 32'h0);

      // Writes to the data registers change nothing.
      cur_key = 4'hD;
      hold(7);
      step(cur_key, cur_sw, 1'b1, A_KEY, 32'hFF);
      read(A_KEY, v);   check("wr_key_kdata", v, 32'h2);
      read(A_KCTRL, v); check("wr_key_kctrl", v, 32'h2);
      step(cur_key, cur_sw, 1'b1, A_SW, 32'hFF);
      read(A_SW, v);    check("wr_sw_sdata", v, 32'h2A5);
      cur_key = 4'hF;
      hold(7);
      step(cur_key, cur_sw, 1'b1, A_KCTRL, 32'h1F);

      // W1C of bit 3 on the very edge key 3's press is accepted: set wins.
      cur_key = 4'h7;
      hold(5);
      step(cur_key, cur_sw, 1'b1, A_KCTRL, 32'h8);
      read(A_KCTRL, v); check("set_wins", v, 32'h8);
      read(A_KEY, v);   check("k3_kdata", v, 32'h8);
      cur_key = 4'hF;
      hold(7);
      step(cur_key, cur_sw, 1'b1, A_KCTRL, 32'h1F);

      // Partial debounce count discarded by reset.
      cur_sw = 10'h000;
      hold(7);
      cur_sw = 10'h200;
      hold(4);
      pulse_reset();
      hold(5);
      read(A_SW, v); check("rst_restart_before", v, 32'h0);
      hold(1);
      read(A_SW, v); check("rst_restart_after", v, 32'h200);

      // Randomised segments: levels held 1..9 cycles, occasional stores.
      for (int seg = 0; seg < 40; seg++) begin
         int len;
         cur_key = 4'($urandom);
         cur_sw  = 10'($urandom);
         len     = int'($urandom_range(1, 9));
         for (int i = 0; i < len; i++) begin
            logic        we;
            logic [31:0] wa;
            we = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
               0:       wa = A_KEY;
               1:       wa = A_SW;
               2:       wa = A_NONE;
               default: wa = A_KCTRL;
            endcase
            step(cur_key, cur_sw, we, wa, $urandom);
         end
      end
      cur_key = 4'hF;
      hold(8);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
